nave_controller: RTL and testbench

- Per-frame motion and fire sequencer for the player ship sprite and its single missile.
- Samples debounced buttons and produces the registered ship and missile coordinates consumed by the ship and missile sprite renderers.
- Coordinates change only once per frame, on a tick derived from the falling edge of vsync, so the renderers never see a mid-frame move.
- Sits between the input/debounce logic and the sprite/compositor stage.

---
 rtl/nave_pkg.sv | 20 ++
 rtl/nave_controller_if.sv | 35 +++
 rtl/nave_controller_frame_tick_gen.sv | 30 +++
 rtl/nave_controller.sv | 187 ++++++++++++++++++
 tb/tb_nave_controller.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/nave_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nave_pkg
// Brief    : Shared types and constants for the player ship controller.
// Revision : 1.0
// ---------------------------------------------------------------------------
package nave_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } missile_state_t;

endpackage
`default_nettype wire

// File: rtl/nave_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nave_controller_if
// Brief    : Button/vsync inputs and sprite coordinate outputs of the ship controller.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface nave_controller_if;
  import nave_pkg::*;

  logic               vsync;
  logic               btn_left;
  logic               btn_right;
  logic               btn_fire;
  logic               missile_hit;
  logic [COORD_W-1:0] ship_x;
  logic [COORD_W-1:0] ship_y;
  logic [COORD_W-1:0] missile_x;
  logic [COORD_W-1:0] missile_y;
  logic               missile_active;
  logic               frame_tick;

  // Controller side
  modport master (
    input  vsync, btn_left, btn_right, btn_fire, missile_hit,
    output ship_x, ship_y, missile_x, missile_y, missile_active, frame_tick
  );

  // Input logic / renderer side
  modport slave (
    output vsync, btn_left, btn_right, btn_fire, missile_hit,
    input  ship_x, ship_y, missile_x, missile_y, missile_active, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/nave_controller_frame_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : frame_tick_gen
// Brief    : Registers vsync and emits a one-cycle pulse after its falling edge.
// Revision : 1.0
// ---------------------------------------------------------------------------
module frame_tick_gen (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic vsync,
  output logic      frame_tick
);

  logic r_vsync_q;
  logic r_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_q <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      r_tick    <= r_vsync_q & ~vsync;
    end
  end

  assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/nave_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nave_controller
// Brief    : Per-frame ship motion and single-missile fire sequencer.
//            Define SHIP_WRAP_EN to wrap the ship at the screen edges.
// Revision : 1.0
// ---------------------------------------------------------------------------
module nave_controller #(
  parameter int SCREEN_W        = 640,
  parameter int SHIP_W          = 32,
  parameter int SHIP_Y          = 448,
  parameter int START_X         = 304,
  parameter int SPEED           = 4,
  parameter int MISSILE_H       = 8,
  parameter int MISSILE_SPEED   = 8,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  wire logic           clk,
  input  wire logic           reset,
  nave_controller_if.master   bus
);
  import nave_pkg::*;

  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [COORD_W:0]   c_max_x     = (COORD_W+1)'(SCREEN_W - SHIP_W);
  localparam logic [COORD_W:0]   c_speed     = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0]   c_fire_ofs  = (COORD_W+1)'(SHIP_W / 2 - 1);
  localparam logic [COORD_W-1:0] c_start_x   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] c_ship_y    = COORD_W'(SHIP_Y);
  localparam logic [COORD_W-1:0] c_launch_y  = COORD_W'(SHIP_Y - MISSILE_H);
  localparam logic [COORD_W-1:0] c_m_speed   = COORD_W'(MISSILE_SPEED);
  localparam logic [CNT_W-1:0]   c_cooldown  = CNT_W'(COOLDOWN_FRAMES);

  missile_state_t     r_state;
  missile_state_t     w_state_next;
  logic [COORD_W-1:0] r_ship_x;
  logic [COORD_W-1:0] r_missile_x;
  logic [COORD_W-1:0] r_missile_y;
  logic               r_missile_active;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_fire;

  logic [COORD_W-1:0] w_ship_x_next;
  logic [COORD_W-1:0] w_missile_x_next;
  logic [COORD_W-1:0] w_missile_y_next;
  logic               w_missile_active_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_fire_next;

  logic               w_tick;
  logic [COORD_W:0]   w_x_ext;
  logic [COORD_W:0]   w_x_plus;
  logic               w_move_left;
  logic               w_move_right;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .vsync      (bus.vsync),
    .frame_tick (w_tick)
  );

  assign w_x_ext      = {1'b0, r_ship_x};
  assign w_x_plus     = w_x_ext + c_speed;
  assign w_move_left  = bus.btn_left & ~bus.btn_right;
  assign w_move_right = bus.btn_right & ~bus.btn_left;

  // Ship motion, evaluated at one bit wider than the coordinate
  always_comb begin
    w_ship_x_next = r_ship_x;
    if (w_tick) begin
      if (w_move_left) begin
        if (w_x_ext < c_speed) begin
`ifdef SHIP_WRAP_EN
          w_ship_x_next = c_max_x[COORD_W-1:0];
`else
          w_ship_x_next = '0;
`endif
        end else begin
          w_ship_x_next = COORD_W'(w_x_ext - c_speed);
        end
      end else if (w_move_right) begin
        if (w_x_plus > c_max_x) begin
`ifdef SHIP_WRAP_EN
          w_ship_x_next = '0;
`else
          w_ship_x_next = c_max_x[COORD_W-1:0];
`endif
        end else begin
          w_ship_x_next = w_x_plus[COORD_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A hit ends the flight in any cycle and wins over the same-cycle tick
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_tick && r_fire) w_state_next = FLYING;
      end
      FLYING: begin
        if (bus.missile_hit) w_state_next = COOLDOWN;
        else if (w_tick && (r_missile_y < c_m_speed)) w_state_next = COOLDOWN;
      end
      COOLDOWN: begin
        if (w_tick && (r_cnt == '0)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_missile_x_next      = r_missile_x;
    w_missile_y_next      = r_missile_y;
    w_missile_active_next = r_missile_active;
    w_cnt_next            = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_tick && r_fire) begin
          w_missile_x_next      = COORD_W'(w_x_ext + c_fire_ofs);
          w_missile_y_next      = c_launch_y;
          w_missile_active_next = 1'b1;
        end
      end
      FLYING: begin
        if (bus.missile_hit) begin
          w_missile_active_next = 1'b0;
          w_cnt_next            = c_cooldown;
        end else if (w_tick) begin
          if (r_missile_y < c_m_speed) begin
            w_missile_active_next = 1'b0;
            w_cnt_next            = c_cooldown;
          end else begin
            w_missile_y_next = r_missile_y - c_m_speed;
          end
        end
      end
      COOLDOWN: begin
        if (w_tick && (r_cnt != '0)) w_cnt_next = r_cnt - 1'b1;
      end
      default: begin
        w_missile_active_next = 1'b0;
      end
    endcase
  end

  // Latch has already been seen by the FSM when it clears on the tick
  assign w_fire_next = bus.btn_fire | (r_fire & ~w_tick);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ship_x         <= c_start_x;
      r_missile_x      <= '0;
      r_missile_y      <= '0;
      r_missile_active <= 1'b0;
      r_cnt            <= '0;
      r_fire           <= 1'b0;
    end else begin
      r_ship_x         <= w_ship_x_next;
      r_missile_x      <= w_missile_x_next;
      r_missile_y      <= w_missile_y_next;
      r_missile_active <= w_missile_active_next;
      r_cnt            <= w_cnt_next;
      r_fire           <= w_fire_next;
    end
  end

  assign bus.ship_x         = r_ship_x;
  assign bus.ship_y         = c_ship_y;
  assign bus.missile_x      = r_missile_x;
  assign bus.missile_y      = r_missile_y;
  assign bus.missile_active = r_missile_active;
  assign bus.frame_tick     = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_nave_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_nave_controller
// Brief    : Directed self-checking bench for nave_controller.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_nave_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;
  int   last_ticks;
  int   exp_x;

  nave_controller_if bus ();

  nave_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One vsync low pulse; counts frame_tick cycles and optionally hits on the tick
  task automatic frame(input bit hit_on_tick);
    int ticks;
    ticks = 0;
    @(negedge clk);
    bus.vsync = 1'b0;
    @(negedge clk);
    if (bus.frame_tick) ticks++;
    if (hit_on_tick) bus.missile_hit = 1'b1;
    bus.vsync = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.missile_hit = 1'b0;
      if (bus.frame_tick) ticks++;
    end
    last_ticks = ticks;
  endtask

  task automatic fire_pulse();
    @(negedge clk);
    bus.btn_fire = 1'b1;
    @(negedge clk);
    bus.btn_fire = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic int model_right(input int x);
`ifdef SHIP_WRAP_EN
    return (x + 4 > 608) ? 0 : x + 4;
`else
    return (x + 4 > 608) ? 608 : x + 4;
`endif
  endfunction

  function automatic int model_left(input int x);
`ifdef SHIP_WRAP_EN
    return (x < 4) ? 608 : x - 4;
`else
    return (x < 4) ? 0 : x - 4;
`endif
  endfunction

  initial begin
    int ticks;
    reset           = 1'b1;
    bus.vsync       = 1'b1;
    bus.btn_left    = 1'b0;
    bus.btn_right   = 1'b0;
    bus.btn_fire    = 1'b0;
    bus.missile_hit = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_ship_x", bus.ship_x, 304);
    chk("reset_ship_y", bus.ship_y, 448);
    chk("reset_missile_x", bus.missile_x, 0);
    chk("reset_missile_y", bus.missile_y, 0);
    chk("reset_active", bus.missile_active, 0);
    chk("reset_tick", bus.frame_tick, 0);
    reset = 1'b0;
    @(negedge clk);

    // Idle frames
    for (int i = 0; i < 3; i++) begin
      frame(1'b0);
      chk("idle_tick_width", last_ticks, 1);
      chk("idle_ship_x", bus.ship_x, 304);
      chk("idle_active", bus.missile_active, 0);
    end

    // Right held, saturating (or wrapping) at the right edge
    exp_x = 304;
    bus.btn_right = 1'b1;
    for (int i = 0; i < 100; i++) begin
      frame(1'b0);
      exp_x = model_right(exp_x);
      chk("right_ship_x", bus.ship_x, exp_x);
    end

    bus.btn_left = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame(1'b0);
      chk("both_ship_x", bus.ship_x, exp_x);
    end

    bus.btn_right = 1'b0;
    for (int i = 0; i < 160; i++) begin
      frame(1'b0);
      exp_x = model_left(exp_x);
      chk("left_ship_x", bus.ship_x, exp_x);
    end
    bus.btn_left = 1'b0;

    // Full missile flight from the reset position
    do_reset();
    fire_pulse();
    frame(1'b0);
    chk("launch_x", bus.missile_x, 319);
    chk("launch_y", bus.missile_y, 440);
    chk("launch_active", bus.missile_active, 1);
    for (int k = 1; k <= 55; k++) begin
      frame(1'b0);
      chk("fly_y", bus.missile_y, 440 - 8 * k);
      chk("fly_active", bus.missile_active, 1);
    end
    frame(1'b0);
    chk("end_active", bus.missile_active, 0);
    chk("end_y", bus.missile_y, 0);
    chk("end_x", bus.missile_x, 319);
    for (int i = 0; i < 16; i++) begin
      fire_pulse();
      frame(1'b0);
      chk("cooldown_no_fire", bus.missile_active, 0);
    end
    fire_pulse();
    frame(1'b0);
    chk("refire_active", bus.missile_active, 1);
    chk("refire_y", bus.missile_y, 440);

    // Hit on the tick cycle at y=200
    for (int i = 0; i < 30; i++) frame(1'b0);
    chk("pre_hit_y", bus.missile_y, 200);
    frame(1'b1);
    chk("hit_active", bus.missile_active, 0);
    chk("hit_y_hold", bus.missile_y, 200);
    fire_pulse();
    frame(1'b0);
    chk("hit_cooldown", bus.missile_active, 0);
    chk("hit_cooldown_y", bus.missile_y, 200);

    // Launch uses the pre-move ship position, then reset mid-flight
    do_reset();
    bus.btn_right = 1'b1;
    for (int i = 0; i < 3; i++) frame(1'b0);
    chk("pre_fire_ship_x", bus.ship_x, 316);
    fire_pulse();
    frame(1'b0);
    bus.btn_right = 1'b0;
    chk("premove_missile_x", bus.missile_x, 331);
    chk("premove_ship_x", bus.ship_x, 320);
    frame(1'b0);
    frame(1'b0);
    chk("midflight_y", bus.missile_y, 424);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_active", bus.missile_active, 0);
    chk("async_ship_x", bus.ship_x, 304);
    chk("async_missile_y", bus.missile_y, 0);
    @(negedge clk);
    reset = 1'b0;
    ticks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.frame_tick) ticks++;
    end
    chk("no_tick_after_reset", ticks, 0);
    frame(1'b0);
    chk("first_tick_after_reset", last_ticks, 1);
    chk("post_reset_ship_x", bus.ship_x, 304);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
